// File: rtl/race_ctl_if.sv
`default_nettype none
// ============================================================================
// Module      : race_ctl_if
// Description : Signal bundle between the race sequencer and its neighbours.
//               The keyboard/frame-timing block and the two car position
//               controllers drive the inputs. The car controllers and the
//               HUD/overlay consume the outputs.
//   modport master : drives frame_ended, start, xpos0/1, ypos0/1;
//                    observes car_rst, car_en, state, countdown, lap0/1,
//                    race_frames, winner
//   modport slave  : the race sequencer side (directions mirrored)
// Revision    : 1.0 - initial release
// ============================================================================
interface race_ctl_if;
    logic        frame_ended;   // one-cycle pulse per video frame
    logic        start;         // start key level
    logic [10:0] xpos0;         // car 0 x position
    logic [10:0] ypos0;         // car 0 y position
    logic [10:0] xpos1;         // car 1 x position
    logic [10:0] ypos1;         // car 1 y position
    logic        car_rst;       // hold both cars at their start position
    logic        car_en;        // cars may move
    logic [1:0]  state;         // 00 IDLE, 01 COUNTDOWN, 10 RACE, 11 FINISH
    logic [1:0]  countdown;     // current countdown digit
    logic [3:0]  lap0;          // laps completed by car 0
    logic [3:0]  lap1;          // laps completed by car 1
    logic [15:0] race_frames;   // frames elapsed in RACE
    logic [1:0]  winner;        // 00 none, 01 car0, 10 car1, 11 tie

    modport master (
        output frame_ended, start, xpos0, ypos0, xpos1, ypos1,
        input  car_rst, car_en, state, countdown, lap0, lap1, race_frames, winner
    );

    modport slave (
        input  frame_ended, start, xpos0, ypos0, xpos1, ypos1,
        output car_rst, car_en, state, countdown, lap0, lap1, race_frames, winner
    );
endinterface
`default_nettype wire

// File: rtl/race_ctl.sv
`default_nettype none
// ============================================================================
// Module      : race_ctl
// Description : Race sequencer for the two-car game. Steps through
//               IDLE -> COUNTDOWN -> RACE -> FINISH. It gates car motion,
//               counts laps per car from the car positions, times the race
//               in frames and declares the winner.
// Ports       : pclk - pixel clock, all logic on the rising edge
//               rst  - asynchronous, active-low reset
//               bus  - race_ctl_if.slave (frame_ended, start, car positions
//                      in; car_rst, car_en, state, countdown, lap0/1,
//                      race_frames, winner out)
// Options     : RACE_TIMEOUT_EN - when defined, the race ends with no
//               winner once race_frames reaches TIMEOUT_FRAMES.
// Revision    : 1.0 - initial release
// ============================================================================
module race_ctl #(
    parameter int LAPS           = 3,
    parameter int COUNT_FROM     = 3,
    parameter int COUNT_FRAMES   = 60,
    parameter int CHECK_Y        = 300,
    parameter int FINISH_X_MIN   = 400,
    parameter int FINISH_X_MAX   = 560,
    parameter int FINISH_Y       = 600,
    parameter int TIMEOUT_FRAMES = 3600
) (
    input wire        pclk,
    input wire        rst,
    race_ctl_if.slave bus
);

    localparam int c_cnt_w = (COUNT_FRAMES > 2) ? $clog2(COUNT_FRAMES) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_last   = c_cnt_w'(COUNT_FRAMES - 1);
    localparam logic [1:0]         c_count_from = 2'(COUNT_FROM);
    localparam logic [3:0]         c_laps       = 4'(LAPS);
    localparam logic [10:0]        c_check_y    = 11'(CHECK_Y);
    localparam logic [10:0]        c_fx_min     = 11'(FINISH_X_MIN);
    localparam logic [10:0]        c_fx_max     = 11'(FINISH_X_MAX);
    localparam logic [10:0]        c_fy         = 11'(FINISH_Y);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_COUNTDOWN = 2'b01,
        ST_RACE      = 2'b10,
        ST_FINISH    = 2'b11
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_start_q;
    logic               r_start_vld;
    logic [c_cnt_w-1:0] r_frame_cnt, w_frame_cnt_nxt;
    logic [1:0]         r_countdown, w_countdown_nxt;
    logic [3:0]         r_lap0, w_lap0_nxt;
    logic [3:0]         r_lap1, w_lap1_nxt;
    logic               r_arm0, w_arm0_nxt;
    logic               r_arm1, w_arm1_nxt;
    logic [15:0]        r_race_frames, w_race_frames_nxt;
    logic [1:0]         r_winner, w_winner_nxt;

    logic        w_start_rise;
    logic        w_zone0, w_zone1;
    logic        w_hit0, w_hit1;
    logic        w_win0, w_win1;
    logic [15:0] w_frames_inc;

    // start_q resets to 0, so a key held down through reset release would
    // otherwise look like a fresh press. r_start_vld masks the first cycle
    // after reset so only a genuine low-to-high transition starts a race.
    assign w_start_rise = bus.start & ~r_start_q & r_start_vld;

    assign w_zone0 = (bus.xpos0 >= c_fx_min) && (bus.xpos0 <= c_fx_max) && (bus.ypos0 >= c_fy);
    assign w_zone1 = (bus.xpos1 >= c_fx_min) && (bus.xpos1 <= c_fx_max) && (bus.ypos1 >= c_fy);

    // A lap only counts when the car has passed the checkpoint since its last
    // lap, so a car parked on the finish line scores once.
    assign w_hit0 = r_arm0 && w_zone0 && (r_lap0 < c_laps);
    assign w_hit1 = r_arm1 && w_zone1 && (r_lap1 < c_laps);
    assign w_win0 = w_hit0 && ((r_lap0 + 4'd1) == c_laps);
    assign w_win1 = w_hit1 && ((r_lap1 + 4'd1) == c_laps);

    assign w_frames_inc = (r_race_frames == 16'hFFFF) ? r_race_frames : r_race_frames + 16'd1;

`ifndef RACE_TIMEOUT_EN
    // The time limit has no effect in this build.
    logic [15:0] w_unused_timeout;
    assign w_unused_timeout = 16'(TIMEOUT_FRAMES);
`endif

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_start_q     <= 1'b0;
            r_start_vld   <= 1'b0;
            r_frame_cnt   <= '0;
            r_countdown   <= 2'd0;
            r_lap0        <= 4'd0;
            r_lap1        <= 4'd0;
            r_arm0        <= 1'b0;
            r_arm1        <= 1'b0;
            r_race_frames <= 16'd0;
            r_winner      <= 2'b00;
        end else begin
            r_state       <= w_state_nxt;
            r_start_q     <= bus.start;
            r_start_vld   <= 1'b1;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_countdown   <= w_countdown_nxt;
            r_lap0        <= w_lap0_nxt;
            r_lap1        <= w_lap1_nxt;
            r_arm0        <= w_arm0_nxt;
            r_arm1        <= w_arm1_nxt;
            r_race_frames <= w_race_frames_nxt;
            r_winner      <= w_winner_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_frame_cnt_nxt   = r_frame_cnt;
        w_countdown_nxt   = r_countdown;
        w_lap0_nxt        = r_lap0;
        w_lap1_nxt        = r_lap1;
        w_arm0_nxt        = r_arm0;
        w_arm1_nxt        = r_arm1;
        w_race_frames_nxt = r_race_frames;
        w_winner_nxt      = r_winner;

        case (r_state)
            ST_IDLE: begin
                // The winner of the previous race stays visible in IDLE and
                // is only cleared when the next countdown begins.
                if (w_start_rise) begin
                    w_state_nxt       = ST_COUNTDOWN;
                    w_countdown_nxt   = c_count_from;
                    w_frame_cnt_nxt   = '0;
                    w_lap0_nxt        = 4'd0;
                    w_lap1_nxt        = 4'd0;
                    w_arm0_nxt        = 1'b0;
                    w_arm1_nxt        = 1'b0;
                    w_race_frames_nxt = 16'd0;
                    w_winner_nxt      = 2'b00;
                end
            end

            ST_COUNTDOWN: begin
                if (bus.frame_ended) begin
                    if (r_frame_cnt == c_cnt_last) begin
                        w_frame_cnt_nxt = '0;
                        if (r_countdown == 2'd1) begin
                            w_state_nxt     = ST_RACE;
                            w_countdown_nxt = 2'd0;
                        end else begin
                            w_countdown_nxt = r_countdown - 2'd1;
                        end
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                    end
                end
            end

            ST_RACE: begin
                if (bus.frame_ended) begin
                    w_race_frames_nxt = w_frames_inc;
                    // Checkpoint (top of track) and finish zone (bottom) do
                    // not overlap, so arming and scoring never coincide.
                    w_arm0_nxt = r_arm0 | (bus.ypos0 < c_check_y);
                    w_arm1_nxt = r_arm1 | (bus.ypos1 < c_check_y);
                    if (w_hit0) begin
                        w_lap0_nxt = r_lap0 + 4'd1;
                        w_arm0_nxt = 1'b0;
                    end
                    if (w_hit1) begin
                        w_lap1_nxt = r_lap1 + 4'd1;
                        w_arm1_nxt = 1'b0;
                    end
                    if (w_win0 || w_win1) begin
                        w_state_nxt  = ST_FINISH;
                        w_winner_nxt = {w_win1, w_win0};
                    end
`ifdef RACE_TIMEOUT_EN
                    else if (w_frames_inc >= 16'(TIMEOUT_FRAMES)) begin
                        w_state_nxt  = ST_FINISH;
                        w_winner_nxt = 2'b00;
                    end
`endif
                end
            end

            ST_FINISH: begin
                if (w_start_rise) begin
                    w_state_nxt       = ST_IDLE;
                    w_countdown_nxt   = 2'd0;
                    w_frame_cnt_nxt   = '0;
                    w_lap0_nxt        = 4'd0;
                    w_lap1_nxt        = 4'd0;
                    w_arm0_nxt        = 1'b0;
                    w_arm1_nxt        = 1'b0;
                    w_race_frames_nxt = 16'd0;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.state       = r_state;
    assign bus.car_rst     = (r_state == ST_IDLE) || (r_state == ST_COUNTDOWN);
    assign bus.car_en      = (r_state == ST_RACE);
    assign bus.countdown   = r_countdown;
    assign bus.lap0        = r_lap0;
    assign bus.lap1        = r_lap1;
    assign bus.race_frames = r_race_frames;
    assign bus.winner      = r_winner;

endmodule
`default_nettype wire
